// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI peripheral engine.
package spi_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_t;

    // {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    localparam int unsigned SPI_D_WIDTH_DEF = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous bus line, with single-shot rise/fall detection
// taken from the last synchronizer stage against a delay flop.
module spi_sync_edge #(
    parameter int unsigned SYNC_DEPTH = 2,
    parameter logic        RESET_VAL  = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  dly_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_DEPTH{RESET_VAL}};
            dly_q  <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], din};
            dly_q  <= sync_q[SYNC_DEPTH-1];
        end
    end

    assign rise = sync_q[SYNC_DEPTH-1] & ~dly_q;
    assign fall = ~sync_q[SYNC_DEPTH-1] & dly_q;

endmodule

// File: rtl/spi_slave_core.sv
// SPI peripheral engine: oversamples sclk/ss_n/mosi, shifts per cpol/cpha, and exchanges
// words with the register block through a TX holding register and an rx_valid strobe.
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int unsigned D_WIDTH    = SPI_D_WIDTH_DEF,
    parameter int unsigned SYNC_DEPTH = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               cpol,
    input  logic               cpha,
    input  logic [D_WIDTH-1:0] tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic [D_WIDTH-1:0] rx_data,
    output logic               rx_valid,
    output logic               busy,
    output logic               tx_underrun,
    output logic               frame_abort,
    input  logic               sclk,
    input  logic               ss_n,
    input  logic               mosi,
    output logic               miso,
    output logic               miso_oe
);

    localparam int unsigned      CNT_W    = $clog2(D_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(D_WIDTH - 1);

    spi_state_t             state, state_n;
    logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic [SYNC_DEPTH-1:0]  mosi_sync;
    logic                   mosi_s;
    logic                   cpol_q, cpha_q;
    logic [CNT_W-1:0]       bit_cnt;
    logic [D_WIDTH-2:0]     rx_shift;
    logic [D_WIDTH-1:0]     rx_next, tx_shift, hold_q;
    logic                   hold_full, rx_done, unr_pend;
    logic                   lead_edge, trail_edge, sample_edge, shift_edge;
    logic                   start_frame, end_frame, word_done, load_word, load_cpha, tx_write;

    spi_sync_edge #(.SYNC_DEPTH(SYNC_DEPTH), .RESET_VAL(1'b0)) u_sync_sclk (
        .clock (clock),
        .reset (reset),
        .din   (sclk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.SYNC_DEPTH(SYNC_DEPTH), .RESET_VAL(1'b1)) u_sync_ss (
        .clock (clock),
        .reset (reset),
        .din   (ss_n),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) mosi_sync <= '1;
        else       mosi_sync <= {mosi_sync[SYNC_DEPTH-2:0], mosi};
    end
    assign mosi_s = mosi_sync[SYNC_DEPTH-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n     = state;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        lead_edge   = cpol_q ? sclk_fall : sclk_rise;
        trail_edge  = cpol_q ? sclk_rise : sclk_fall;
        sample_edge = cpha_q ? trail_edge : lead_edge;
        shift_edge  = cpha_q ? lead_edge : trail_edge;
        case (state)
            ST_IDLE: begin
                if (ss_fall && enable) begin
                    state_n     = ST_ACTIVE;
                    start_frame = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (ss_rise || !enable) begin
                    state_n   = ST_IDLE;
                    end_frame = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        word_done = (state == ST_ACTIVE) && !end_frame && sample_edge && (bit_cnt == LAST_BIT);
        load_word = start_frame || word_done;
        load_cpha = start_frame ? cpha : cpha_q;
        tx_write  = tx_valid && !hold_full;
        rx_next   = {rx_shift, mosi_s};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_done     <= 1'b0;
            rx_valid    <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            rx_done     <= word_done;
            rx_valid    <= rx_done;
            frame_abort <= end_frame && (bit_cnt != '0);
            if (start_frame) begin
                cpol_q  <= cpol;
                cpha_q  <= cpha;
                bit_cnt <= '0;
            end else if (end_frame) begin
                bit_cnt <= '0;
            end else if (state == ST_ACTIVE && sample_edge) begin
                rx_shift <= rx_next[D_WIDTH-2:0];
                if (word_done) begin
                    rx_data <= rx_next;
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
        end
    end

    // A mid-frame load from an empty register only counts as an underrun once the next
    // word actually starts (its leading edge); a frame ending on the boundary never pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_q      <= '0;
            hold_full   <= 1'b0;
            tx_shift    <= '1;
            miso        <= 1'b1;
            tx_underrun <= 1'b0;
            unr_pend    <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            if (tx_write) begin
                hold_q    <= tx_data;
                hold_full <= 1'b1;
            end else if (load_word) begin
                hold_full <= 1'b0;
            end
            if (end_frame) begin
                miso     <= 1'b1;
                unr_pend <= 1'b0;
            end else if (load_word) begin
                tx_shift <= hold_full ? hold_q : '1;
                if (!load_cpha) miso <= hold_full ? hold_q[D_WIDTH-1] : 1'b1;
                if (!hold_full) begin
                    if (start_frame) tx_underrun <= 1'b1;
                    else             unr_pend    <= 1'b1;
                end
            end else if (state == ST_ACTIVE) begin
                if (lead_edge && unr_pend) begin
                    tx_underrun <= 1'b1;
                    unr_pend    <= 1'b0;
                end
                if (shift_edge) begin
                    if (bit_cnt != '0) begin
                        tx_shift <= {tx_shift[D_WIDTH-2:0], 1'b0};
                        miso     <= tx_shift[D_WIDTH-2];
                    end else if (cpha_q) begin
                        miso <= tx_shift[D_WIDTH-1];
                    end
                end
            end
        end
    end

    assign busy     = (state == ST_ACTIVE);
    assign miso_oe  = busy;
    assign tx_ready = ~hold_full;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: a behavioural SPI initiator drives frames, expected rx words go to a
// scoreboard queue checked by an rx_valid monitor, and the initiator checks the miso stream.
module tb_spi_slave_core;
    import spi_pkg::*;

    localparam int unsigned DW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          cpol = 1'b0;
    logic          cpha = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid, busy, tx_underrun, frame_abort, miso, miso_oe;
    logic          sclk = 1'b0;
    logic          ss_n = 1'b1;
    logic          mosi = 1'b1;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] exp_rx_q[$];
    int            rx_cnt = 0, unr_cnt = 0, abt_cnt = 0;
    time           t_sample = 0;
    logic          frame_on = 1'b0;
    logic          miso_may_change = 1'b0;
    logic [DW-1:0] m_words[3];
    logic [DW-1:0] s_words[3];

    always #5 clock = ~clock;

    spi_slave_core #(.D_WIDTH(DW), .SYNC_DEPTH(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .cpol        (cpol),
        .cpha        (cpha),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .busy        (busy),
        .tx_underrun (tx_underrun),
        .frame_abort (frame_abort),
        .sclk        (sclk),
        .ss_n        (ss_n),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // rx scoreboard monitor plus pulse counters
    always @(negedge clock) begin
        if (!reset) begin
            if (rx_valid) begin
                rx_cnt++;
                if (exp_rx_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rx_unexpected: rx_valid with rx_data=0x%0h, expected none", rx_data);
                end else begin
                    check("rx_data", 32'(rx_data), 32'(exp_rx_q.pop_front()));
                    check("rx_latency", 32'($time - t_sample), 32'd40);
                end
            end
            if (tx_underrun) unr_cnt++;
            if (frame_abort) abt_cnt++;
        end
    end

    always @(miso) begin
        if (frame_on && !reset) check("miso_on_shift_edge", 32'(miso_may_change), 32'd1);
    end

    task automatic half();
        repeat (4) @(negedge clock);
    endtask

    task automatic set_mode(input logic [1:0] m);
        cpol = m[1];
        cpha = m[0];
        sclk = m[1];
    endtask

    task automatic write_tx(input logic [DW-1:0] d);
        int unsigned n = 0;
        while (tx_ready !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (tx_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tx_ready_timeout: tx_ready=%b after %0d cycles, expected 1", tx_ready, n);
        end else begin
            tx_data  = d;
            tx_valid = 1'b1;
            @(negedge clock);
            tx_valid = 1'b0;
            check("tx_ready_after_write", 32'(tx_ready), 32'd0);
        end
    endtask

    task automatic xfer_bits(input logic [DW-1:0] w, input int unsigned nbits,
                             input logic [DW-1:0] exp_miso, input logic chk);
        logic [DW-1:0] got;
        got = '0;
        for (int unsigned i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi = w[DW-1-i];
                half();
                sclk = ~cpol;
                got[DW-1-i] = miso;
                t_sample = $time;
                miso_may_change = (i == DW - 1);
                half();
                sclk = cpol;
                miso_may_change = 1'b1;
            end else begin
                half();
                sclk = ~cpol;
                mosi = w[DW-1-i];
                miso_may_change = 1'b1;
                half();
                sclk = cpol;
                got[DW-1-i] = miso;
                t_sample = $time;
                miso_may_change = 1'b0;
            end
        end
        if (chk) check("miso_word", 32'(got), 32'(exp_miso));
    endtask

    task automatic run_frame(input logic [1:0] m, input int unsigned nw, input logic preload);
        set_mode(m);
        half();
        if (preload) write_tx(s_words[0]);
        for (int unsigned k = 0; k < nw; k++) exp_rx_q.push_back(m_words[k]);
        frame_on = 1'b1;
        miso_may_change = 1'b1;
        ss_n = 1'b0;
        fork
            begin
                for (int unsigned k = 0; k < nw; k++)
                    xfer_bits(m_words[k], DW, preload ? s_words[k] : '1, 1'b1);
            end
            begin
                if (preload)
                    for (int unsigned k = 1; k < nw; k++) write_tx(s_words[k]);
            end
            begin
                half();
                check("busy_in_frame", 32'(busy), 32'd1);
                check("miso_oe_in_frame", 32'(miso_oe), 32'd1);
            end
        join
        half();
        frame_on = 1'b0;
        ss_n = 1'b1;
        half();
        check("busy_after_frame", 32'(busy), 32'd0);
        check("miso_oe_after_frame", 32'(miso_oe), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tx_ready"}, 32'(tx_ready), 32'd1);
        check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_tx_underrun"}, 32'(tx_underrun), 32'd0);
        check({tag, "_frame_abort"}, 32'(frame_abort), 32'd0);
        check({tag, "_miso"}, 32'(miso), 32'd1);
        check({tag, "_miso_oe"}, 32'(miso_oe), 32'd0);
    endtask

    initial begin
        int            u0, r0, a0;
        logic [DW-1:0] prev_rx;
        logic [1:0]    md;
        int unsigned   nw;

        repeat (3) @(negedge clock);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clock);
        check_reset_vals("post_reset");
        enable = 1'b1;
        half();

        // Mode 0 basic word, then modes 1..3 with the same words
        for (int unsigned mi = 0; mi < 4; mi++) begin
            m_words[0] = 8'h3C;
            s_words[0] = 8'hA5;
            u0 = unr_cnt;
            run_frame(2'(mi), 1, 1'b1);
            check("tx_ready_after_load", 32'(tx_ready), 32'd1);
            check("no_underrun_single", 32'(unr_cnt - u0), 32'd0);
        end

        // Three back-to-back words, one word preloaded ahead
        m_words = '{8'h01, 8'h02, 8'h03};
        s_words = '{8'h11, 8'h22, 8'h33};
        u0 = unr_cnt;
        r0 = rx_cnt;
        run_frame(SPI_MODE0, 3, 1'b1);
        check("continuous_rx_count", 32'(rx_cnt - r0), 32'd3);
        check("continuous_no_underrun", 32'(unr_cnt - u0), 32'd0);

        // Empty holding register: all-ones on miso and one underrun pulse
        m_words[0] = 8'h96;
        u0 = unr_cnt;
        run_frame(SPI_MODE0, 1, 1'b0);
        check("underrun_count", 32'(unr_cnt - u0), 32'd1);

        // ss_n rises after 5 bits
        prev_rx = rx_data;
        a0 = abt_cnt;
        r0 = rx_cnt;
        set_mode(SPI_MODE1);
        half();
        write_tx(8'h5A);
        frame_on = 1'b1;
        miso_may_change = 1'b1;
        ss_n = 1'b0;
        xfer_bits(8'hE7, 5, '0, 1'b0);
        half();
        frame_on = 1'b0;
        ss_n = 1'b1;
        half();
        check("abort_count", 32'(abt_cnt - a0), 32'd1);
        check("abort_no_rx_valid", 32'(rx_cnt - r0), 32'd0);
        check("abort_rx_data_held", 32'(rx_data), 32'(prev_rx));
        check("abort_miso_oe", 32'(miso_oe), 32'd0);
        m_words[0] = 8'hC6;
        s_words[0] = 8'h39;
        run_frame(SPI_MODE1, 1, 1'b1);

        // enable drops mid-word, then returns with ss_n still low
        a0 = abt_cnt;
        set_mode(SPI_MODE0);
        half();
        frame_on = 1'b1;
        miso_may_change = 1'b1;
        ss_n = 1'b0;
        xfer_bits(8'hF0, 3, '0, 1'b0);
        frame_on = 1'b0;
        enable = 1'b0;
        half();
        check("enable_drop_abort", 32'(abt_cnt - a0), 32'd1);
        check("enable_drop_busy", 32'(busy), 32'd0);
        enable = 1'b1;
        half();
        check("enable_rise_no_frame", 32'(busy), 32'd0);
        ss_n = 1'b1;
        half();

        // Randomized frames
        u0 = unr_cnt;
        for (int unsigned r = 0; r < 8; r++) begin
            md = 2'($urandom_range(0, 3));
            nw = $urandom_range(1, 3);
            for (int unsigned k = 0; k < 3; k++) begin
                m_words[k] = 8'($urandom);
                s_words[k] = 8'($urandom);
            end
            run_frame(md, nw, 1'b1);
        end
        check("random_no_underrun", 32'(unr_cnt - u0), 32'd0);

        // Reset mid-word
        set_mode(SPI_MODE0);
        half();
        write_tx(8'h81);
        frame_on = 1'b1;
        miso_may_change = 1'b1;
        ss_n = 1'b0;
        xfer_bits(8'h7E, 3, '0, 1'b0);
        frame_on = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check_reset_vals("midword_reset");
        ss_n = 1'b1;
        sclk = cpol;
        half();
        reset = 1'b0;
        half();
        check("post_reset_miso_oe", 32'(miso_oe), 32'd0);
        m_words[0] = 8'h4D;
        s_words[0] = 8'hB2;
        run_frame(SPI_MODE0, 1, 1'b1);

        for (int unsigned n = 0; n < 100 && exp_rx_q.size() != 0; n++) @(negedge clock);
        check("rx_queue_drained", 32'(exp_rx_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
